// File: rtl/rejestr_uniwersalny.sv
// Universal shift register: parallel load, multi-bit serial shift left/right with per-edge fill.
// Optional rotate support is enabled by defining REJESTR_ROTACJA_EN.
module rejestr_uniwersalny #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [1:0]    S,
  input  logic [CW-1:0] N,
  input  logic          ROT,
  input  logic          SIR,
  input  logic          SIL,
  input  logic [W-1:0]  I,
  output logic [W-1:0]  Q,
  output logic          SOUT,
  output logic          BUSY,
  output logic          DONE
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t        state, state_nx;
  logic [W-1:0]  q_r, q_nx;
  logic          sout_r, sout_nx;
  logic          done_r, done_nx;
  logic [CW-1:0] count_r, count_nx;
  logic          left_r, left_nx;
  logic [CW-1:0] n_sat;
  logic          out_bit;
  logic          fill_bit;
  logic [W-1:0]  shifted;

`ifdef REJESTR_ROTACJA_EN
  logic rot_r, rot_nx;
`else
  logic rot_unused;
  assign rot_unused = ROT;
`endif

  assign n_sat = (N > CW'(W)) ? CW'(W) : N;

  // Fill is taken from the live serial inputs on every shift edge, not latched at START.
  always_comb begin
    out_bit = left_r ? q_r[W-1] : q_r[0];
`ifdef REJESTR_ROTACJA_EN
    fill_bit = rot_r ? out_bit : (left_r ? SIL : SIR);
`else
    fill_bit = left_r ? SIL : SIR;
`endif
    shifted = left_r ? {q_r[W-2:0], fill_bit} : {fill_bit, q_r[W-1:1]};
  end

  always_comb begin
    state_nx = state;
    q_nx     = q_r;
    sout_nx  = sout_r;
    done_nx  = 1'b0;
    count_nx = count_r;
    left_nx  = left_r;
`ifdef REJESTR_ROTACJA_EN
    rot_nx   = rot_r;
`endif
    case (state)
      IDLE: begin
        if (START) begin
          case (S)
            2'b11: begin
              q_nx    = I;
              done_nx = 1'b1;
            end
            2'b01, 2'b10: begin
              if (n_sat == '0) begin
                done_nx = 1'b1;
              end else begin
                left_nx  = S[1];
`ifdef REJESTR_ROTACJA_EN
                rot_nx   = ROT;
`endif
                count_nx = n_sat;
                state_nx = SHIFT;
              end
            end
            default: done_nx = 1'b1;
          endcase
        end
      end
      SHIFT: begin
        q_nx     = shifted;
        sout_nx  = out_bit;
        count_nx = count_r - CW'(1);
        if (count_r == CW'(1)) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      q_r     <= '0;
      sout_r  <= 1'b0;
      done_r  <= 1'b0;
      count_r <= '0;
      left_r  <= 1'b0;
`ifdef REJESTR_ROTACJA_EN
      rot_r   <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      q_r     <= q_nx;
      sout_r  <= sout_nx;
      done_r  <= done_nx;
      count_r <= count_nx;
      left_r  <= left_nx;
`ifdef REJESTR_ROTACJA_EN
      rot_r   <= rot_nx;
`endif
    end
  end

  assign Q    = q_r;
  assign SOUT = sout_r;
  assign DONE = done_r;
  assign BUSY = (state == SHIFT);

endmodule

// File: tb/tb_rejestr_uniwersalny.sv
// Scoreboard bench for rejestr_uniwersalny: driver pushes model results, monitor checks on DONE.
module tb_rejestr_uniwersalny;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST, START, ROT, SIR, SIL;
  logic [1:0]    S;
  logic [CW-1:0] N;
  logic [W-1:0]  I;
  logic [W-1:0]  Q;
  logic          SOUT, BUSY, DONE;

  rejestr_uniwersalny #(.W(W), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .S(S), .N(N), .ROT(ROT),
    .SIR(SIR), .SIL(SIL), .I(I), .Q(Q), .SOUT(SOUT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] q;
    logic         sout;
    int unsigned  busy;
  } exp_t;

  exp_t         sb[$];
  int unsigned  n_cmp = 0;
  int unsigned  n_bad = 0;
  logic [W-1:0] mq = '0;
  logic         msout = 1'b0;
  int unsigned  busy_cnt = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: whole n-bit shift computed at once from the collected fill bits.
  function automatic void model_shift(input logic left, input logic rot, input int unsigned n,
                                      input logic [W-1:0] fills);
    int unsigned qv, res, fw, mask;
    logic use_rot;
`ifdef REJESTR_ROTACJA_EN
    use_rot = rot;
`else
    use_rot = rot & 1'b0;
`endif
    qv = 32'(mq);
    mask = (32'd1 << W) - 1;
    fw = 0;
    if (!left) begin
      msout = mq[n-1];
      res = use_rot ? ((qv >> n) | (qv << (W - n))) : ((qv >> n) | (32'(fills) << (W - n)));
    end else begin
      msout = mq[W-n];
      for (int j = 0; j < int'(n); j++) fw |= 32'(fills[j]) << (n - 1 - j);
      res = use_rot ? ((qv << n) | (qv >> (W - n))) : ((qv << n) | fw);
    end
    mq = W'(res & mask);
  endfunction

  // Assumes the caller is positioned at a negedge.
  task automatic cmd_body(input logic [1:0] s, input int unsigned n, input logic rot,
                          input logic [W-1:0] data, input int fill_mode);
    int unsigned ne;
    logic [W-1:0] fills;
    logic f;
    exp_t e;
    ne = (n > W) ? W : n;
    fills = '0;
    START = 1'b1; S = s; N = CW'(n); ROT = rot; I = data;
    SIR = 1'($urandom); SIL = 1'($urandom);
    if (s == 2'b11) begin
      mq = data;
      e = '{q: mq, sout: msout, busy: 0};
      sb.push_back(e);
    end else if (s == 2'b00 || ne == 0) begin
      e = '{q: mq, sout: msout, busy: 0};
      sb.push_back(e);
    end else begin
      for (int j = 0; j < int'(ne); j++) begin
        @(negedge CLK);
        START = (j == int'(ne) / 2) ? 1'b1 : 1'($urandom);
        S = 2'($urandom); N = CW'($urandom); ROT = 1'($urandom); I = W'($urandom);
        f = (fill_mode < 0) ? 1'($urandom) : fill_mode[0];
        if (s == 2'b10) begin SIL = f; SIR = 1'($urandom); end
        else begin SIR = f; SIL = 1'($urandom); end
        fills[j] = f;
      end
      model_shift(s == 2'b10, rot, ne, fills);
      e = '{q: mq, sout: msout, busy: ne};
      sb.push_back(e);
    end
  endtask

  task automatic run_cmd(input logic [1:0] s, input int unsigned n, input logic rot,
                         input logic [W-1:0] data, input int fill_mode);
    @(negedge CLK);
    cmd_body(s, n, rot, data, fill_mode);
  endtask

  task automatic idle(input int unsigned c);
    repeat (c) begin
      @(negedge CLK);
      START = 1'b0;
    end
  endtask

  // Monitor: pops one expectation per DONE pulse, BUSY cycles counted since the last DONE.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (RST) begin
        busy_cnt = 0;
      end else begin
        if (BUSY === 1'b1) busy_cnt++;
        if (DONE === 1'b1) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 64'(DONE), 64'd0);
          end else begin
            e = sb.pop_front();
            check("q", 64'(Q), 64'(e.q));
            check("sout", 64'(SOUT), 64'(e.sout));
            check("busy_cycles", 64'(busy_cnt), 64'(e.busy));
          end
          busy_cnt = 0;
        end
      end
    end
  end

  initial begin
    int unsigned waited;
    RST = 1'b1; START = 1'b0; S = '0; N = '0; ROT = 1'b0; SIR = 1'b0; SIL = 1'b0; I = '0;
    repeat (3) @(negedge CLK);
    check("reset_q", 64'(Q), 64'd0);
    check("reset_sout", 64'(SOUT), 64'd0);
    check("reset_busy", 64'(BUSY), 64'd0);
    check("reset_done", 64'(DONE), 64'd0);
    RST = 1'b0;
    cmd_body(2'b11, 0, 1'b0, 8'hA5, 0);
    run_cmd(2'b01, 3, 1'b0, 8'h00, 0);
    idle(2);
    run_cmd(2'b11, 0, 1'b0, 8'h81, 0);
    run_cmd(2'b10, 2, 1'b1, 8'h00, 1);
    run_cmd(2'b11, 0, 1'b0, 8'hFF, 0);
    run_cmd(2'b01, 15, 1'b0, 8'h00, 0);
    run_cmd(2'b00, 5, 1'b0, 8'h00, -1);
    run_cmd(2'b10, 0, 1'b0, 8'h00, -1);
    run_cmd(2'b11, 0, 1'b0, 8'h3C, 0);
    // Reset lands on the second shift edge: no DONE may follow for this command.
    @(negedge CLK); START = 1'b1; S = 2'b10; N = CW'(4); ROT = 1'b0;
    @(negedge CLK); START = 1'b0; SIL = 1'($urandom);
    @(negedge CLK); RST = 1'b1; SIL = 1'($urandom);
    @(negedge CLK);
    check("midreset_q", 64'(Q), 64'd0);
    check("midreset_busy", 64'(BUSY), 64'd0);
    check("midreset_sout", 64'(SOUT), 64'd0);
    mq = '0; msout = 1'b0;
    RST = 1'b0;
    cmd_body(2'b11, 0, 1'b0, 8'h01, 0);
    idle(1);

    for (int k = 0; k < 80; k++) begin
      run_cmd(2'($urandom), $urandom_range(0, 15), 1'($urandom), W'($urandom), -1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(1);

    waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rejestr_uniwersalny.md
REJESTR_UNIWERSALNY -- requirements
Module: rejestr_uniwersalny

Interface
REQ-001 The block SHALL have parameter W, default 8, register width in bits (legal range 2..64).
REQ-002 The block SHALL have derived parameter CW, default $clog2(W+1), width of the shift-amount port.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 CLK  input  1  clock; all state changes on the rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 START  input  1  command strobe, sampled only in IDLE.
REQ-007 S  input  2  command: 00 no-op, 01 shift right (towards bit 0), 10 shift left (towards bit W-1), 11 parallel load.
REQ-008 N  input  CW  shift amount in bits, sampled with START.
REQ-009 ROT  input  1  rotate instead of serial fill, sampled with START.
REQ-010 SIR  input  1  serial data entering bit W-1 on each right shift.
REQ-011 SIL  input  1  serial data entering bit 0 on each left shift.
REQ-012 I  input  W  parallel load data.
REQ-013 Q  output  W  register contents.
REQ-014 SOUT  output  1  last bit shifted out of the register.
REQ-015 BUSY  output  1  high while a multi-cycle shift is in progress.
REQ-016 DONE  output  1  one-cycle pulse marking command completion.

Function
REQ-017 The block SHALL implement an FSM with states IDLE and SHIFT.
REQ-018 In IDLE with START=1 and S=11, Q SHALL take I at that edge; DONE SHALL be 1 for the following cycle; the state SHALL remain IDLE.
REQ-019 In IDLE with START=1 and S=00, or S=01/10 with N=0, Q SHALL be unchanged and DONE SHALL pulse in the following cycle.
REQ-020 In IDLE with START=1, S=01/10 and N>0, the edge SHALL latch direction, ROT and count=min(N,W), and enter SHIFT; Q SHALL be unchanged on that edge.
REQ-021 In SHIFT, each edge SHALL shift Q by one bit, set SOUT to the bit leaving the register, and decrement count.
REQ-022 The edge on which count reaches 0 SHALL return the FSM to IDLE, with DONE=1 in the following cycle; total latency from START to DONE SHALL be N+1 cycles.
REQ-023 BUSY SHALL be 1 in exactly the cycles the FSM is in SHIFT.
REQ-024 The fill bit SHALL be the value of SIR (right) or SIL (left) sampled on each shift edge, not a value latched at START.
REQ-025 START during SHIFT SHALL be ignored, with no queuing.
REQ-026 N greater than W SHALL saturate to W.
REQ-027 DONE SHALL never be high for two consecutive cycles from a single command.
REQ-028 Back-to-back commands SHALL be accepted: START may be asserted in the same cycle DONE is high if the FSM is in IDLE.

Reset
REQ-029 RST=1 at a clock edge SHALL force IDLE, Q=0, SOUT=0, BUSY=0, DONE=0, and count=0, overriding START and any shift in progress.
REQ-030 After reset is released, the first START SHALL be accepted on the first edge with RST=0.

Configuration
REQ-031 Macro REJESTR_ROTACJA_EN SHALL control rotate support.
REQ-032 With REJESTR_ROTACJA_EN defined and latched ROT=1, the bit leaving the register SHALL re-enter at the opposite end instead of SIR/SIL.
REQ-033 Without REJESTR_ROTACJA_EN, ROT SHALL be ignored: the port stays present and unused, and shifts always fill from SIR/SIL.

Verification
REQ-034 W=8; reset, then START S=11 I=8'hA5 -> Q=8'hA5 after 1 edge; DONE high 1 cycle; BUSY never high.
REQ-035 Q=8'hA5; START S=01 N=3 SIR=0 -> BUSY high 3 cycles; Q=8'h14; SOUT=1; DONE in cycle 4 after START.
REQ-036 Q=8'h81; START S=10 N=2 ROT=1 -> with macro Q=8'h06; without macro, SIL=1 -> Q=8'h07.
REQ-037 Q=8'hFF; START S=01 N=15 (saturates to 8) SIR=0 -> 8 BUSY cycles; Q=8'h00; START pulsed mid-shift has no effect.
REQ-038 Q=8'h3C; START S=10 N=4; RST asserted on 2nd SHIFT edge -> Q=0, BUSY=0, no DONE pulse; next START S=11 I=8'h01 -> Q=8'h01.
